// File: rtl/enemy_health_ctrl_pkg.sv
// Shared types, widths and arithmetic helpers for the enemy health controller.
package enemy_pkg;

   // Width of the displayed bar width and of the HP target (0..MAX_HP).
   localparam int BORDER_W = 11;

   // Width of the per-frame down counters (hit flash, blink frame spacing).
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ALIVE = 2'd1,
      DYING = 2'd2,
      DEAD  = 2'd3
   } health_state_t;

   // Saturating subtract: a - b, clamped at zero instead of wrapping.
   function automatic logic [BORDER_W-1:0] sat_sub11(
      input logic [BORDER_W-1:0] a,
      input logic [BORDER_W-1:0] b
   );
      return (b >= a) ? '0 : (a - b);
   endfunction

endpackage

// File: rtl/enemy_health_ctrl_frame_down_counter.sv
// Frame-rate down counter: loadable, decrements once per tick, stops at zero.
// The zero flag is registered alongside the count so consumers see a clean
// flop output rather than a decode of the count.
module frame_down_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         tick,
   output logic         zero
);

   logic [W-1:0] count;
   logic [W-1:0] count_d;
   logic         active_q;

   // Next count: clear beats load, load beats a same-cycle tick.
   always_comb begin
      // NOTE: default assignment first so every path drives count_d and no latch is inferred.
      count_d = count;
      if (clear) begin
         count_d = '0;
      end else if (load) begin
         count_d = load_val;
      end else if (tick && (count != '0)) begin
         count_d = count - W'(1);
      end
   end

   // Count and nonzero flag registers.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: asynchronous reset is in the sensitivity list so state clears without a clock edge.
      if (rst) begin
         count    <= '0;
         active_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments for all flops so every register samples pre-edge values.
         count    <= count_d;
         active_q <= (count_d != '0);
      end
   end

   assign zero = ~active_q;

endmodule

// File: rtl/enemy_health_ctrl.sv
// Enemy hit-point owner and health bar driver. Accepts damage while alive,
// drains the displayed bar toward the true HP once per frame, blinks the bar
// after death and then hides it and raises dead_out until the next spawn.
module enemy_health_ctrl
   import enemy_pkg::*;
#(
   parameter int MAX_HP        = 96,
   parameter int DRAIN_STEP    = 2,
   parameter int HIT_FRAMES    = 8,
   parameter int BLINK_FRAMES  = 6,
   parameter int BLINK_TOGGLES = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                frame_tick_in,
   input  logic                spawn_in,
   input  logic                damage_valid_in,
   input  logic [7:0]          damage_amt_in,
   output logic [BORDER_W-1:0] border_out,
   output logic                valid_out,
   output logic                hit_flash_out,
   output logic                dead_out
);

   localparam int TOG_W = $clog2(BLINK_TOGGLES + 1);

   localparam logic [BORDER_W-1:0] MAX_HP_W   = BORDER_W'(MAX_HP);
   localparam logic [BORDER_W-1:0] STEP_W     = BORDER_W'(DRAIN_STEP);
   localparam logic [CNT_W-1:0]    HIT_LOAD   = CNT_W'(HIT_FRAMES);
   // The blink counter toggles on the tick that finds it at zero, so loading
   // BLINK_FRAMES-1 gives exactly BLINK_FRAMES ticks between toggles.
   localparam logic [CNT_W-1:0]    BLINK_LOAD = CNT_W'(BLINK_FRAMES - 1);
   localparam logic [TOG_W-1:0]    TOG_LAST   = TOG_W'(BLINK_TOGGLES);

   health_state_t       state;
   logic [BORDER_W-1:0] hp_target;
   logic [BORDER_W-1:0] border_drained;
   logic [BORDER_W-1:0] drain_gap;
   logic [TOG_W-1:0]    toggle_cnt;

   logic hit_accept;
   logic enter_dying;
   logic blink_phase;
   logic blink_tick;
   logic blink_zero;
   logic blink_wrap;
   logic flash_zero;

   // Event decode shared by the counters and the state register.
   always_comb begin
      hit_accept  = (state == ALIVE) && damage_valid_in && !spawn_in;
      enter_dying = (state == ALIVE) && (hp_target == '0) && !spawn_in;
      blink_phase = (state == DYING) && (border_out == '0) && (toggle_cnt != TOG_LAST);
      blink_tick  = blink_phase && frame_tick_in && !spawn_in;
      blink_wrap  = blink_tick && blink_zero;
   end

   // One drain step toward the registered (pre-damage) HP target.
   always_comb begin
      border_drained = border_out;
      drain_gap      = '0;
      if (border_out > hp_target) begin
         drain_gap      = border_out - hp_target;
         border_drained = (drain_gap > STEP_W) ? (border_out - STEP_W) : hp_target;
      end
   end

   frame_down_counter #(.W(CNT_W)) u_flash_cnt (
      .clk      (clk),
      .rst      (rst),
      .clear    (spawn_in),
      .load     (hit_accept),
      .load_val (HIT_LOAD),
      .tick     (frame_tick_in),
      .zero     (flash_zero)
   );

   frame_down_counter #(.W(CNT_W)) u_blink_cnt (
      .clk      (clk),
      .rst      (rst),
      .clear    (spawn_in),
      .load     (enter_dying || blink_wrap),
      .load_val (BLINK_LOAD),
      .tick     (blink_tick),
      .zero     (blink_zero)
   );

   assign hit_flash_out = ~flash_zero;

   // Life-cycle state, HP target and the registered bar outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         hp_target  <= '0;
         border_out <= '0;
         valid_out  <= 1'b0;
         dead_out   <= 1'b0;
         toggle_cnt <= '0;
      end else if (spawn_in) begin
         state      <= ALIVE;
         hp_target  <= MAX_HP_W;
         border_out <= MAX_HP_W;
         valid_out  <= 1'b1;
         dead_out   <= 1'b0;
         toggle_cnt <= '0;
      end else begin
         case (state)
            ALIVE: begin
               if (damage_valid_in) begin
                  hp_target <= sat_sub11(hp_target, {3'b000, damage_amt_in});
               end
               if (frame_tick_in) begin
                  border_out <= border_drained;
               end
               if (enter_dying) begin
                  state      <= DYING;
                  toggle_cnt <= '0;
               end
            end
            DYING: begin
               if (frame_tick_in) begin
                  border_out <= border_drained;
               end
               if (blink_wrap) begin
                  valid_out  <= ~valid_out;
                  toggle_cnt <= toggle_cnt + TOG_W'(1);
               end
               if (toggle_cnt == TOG_LAST) begin
                  state     <= DEAD;
                  valid_out <= 1'b0;
                  dead_out  <= 1'b1;
               end
            end
            DEAD: begin
               valid_out <= 1'b0;
               dead_out  <= 1'b1;
            end
            default: begin
               valid_out <= 1'b0;
               dead_out  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_enemy_health_ctrl.sv
// Directed bench for enemy_health_ctrl: a per-cycle vector table for spawn,
// damage and drain behaviour, plus hand-written death and async-reset sequences.
module tb_enemy_health_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_tick_in = 1'b0;
   logic        spawn_in = 1'b0;
   logic        damage_valid_in = 1'b0;
   logic [7:0]  damage_amt_in = 8'd0;
   logic [10:0] border_out;
   logic        valid_out;
   logic        hit_flash_out;
   logic        dead_out;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   enemy_health_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .frame_tick_in   (frame_tick_in),
      .spawn_in        (spawn_in),
      .damage_valid_in (damage_valid_in),
      .damage_amt_in   (damage_amt_in),
      .border_out      (border_out),
      .valid_out       (valid_out),
      .hit_flash_out   (hit_flash_out),
      .dead_out        (dead_out)
   );

   typedef struct {
      string       name;
      logic        spawn;
      logic        dv;
      logic [7:0]  amt;
      logic        tick;
      logic [10:0] border;
      logic        valid;
      logic        flash;
      logic        dead;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input string name, input logic spawn, input logic dv,
                               input logic [7:0] amt, input logic tick,
                               input logic [10:0] border, input logic valid,
                               input logic flash, input logic dead);
      vec_t v;
      v.name = name; v.spawn = spawn; v.dv = dv; v.amt = amt; v.tick = tick;
      v.border = border; v.valid = valid; v.flash = flash; v.dead = dead;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_outs(input string name, input logic [10:0] border, input logic valid,
                             input logic flash, input logic dead);
      check({name, ".border"}, 32'(border_out), 32'(border));
      check({name, ".valid"}, 32'(valid_out), 32'(valid));
      check({name, ".flash"}, 32'(hit_flash_out), 32'(flash));
      check({name, ".dead"}, 32'(dead_out), 32'(dead));
   endtask

   // Drive one cycle of inputs, clock it in, sample 1 time unit after the edge.
   task automatic step(input logic s, input logic dv, input logic [7:0] amt, input logic t);
      spawn_in        = s;
      damage_valid_in = dv;
      damage_amt_in   = amt;
      frame_tick_in   = t;
      @(posedge clk);
      #1;
      spawn_in        = 1'b0;
      damage_valid_in = 1'b0;
      damage_amt_in   = 8'd0;
      frame_tick_in   = 1'b0;
   endtask

   initial begin
      // Vector table: each row is one clock of inputs and the outputs after it.
      add("idle",       0, 0, 8'd0,  0, 11'd0,  0, 0, 0);
      add("idle_dmg",   0, 1, 8'd50, 0, 11'd0,  0, 0, 0);
      add("idle_tick",  0, 0, 8'd0,  1, 11'd0,  0, 0, 0);
      add("spawn_dmg",  1, 1, 8'd50, 0, 11'd96, 1, 0, 0);
      add("hit30",      0, 1, 8'd30, 0, 11'd96, 1, 1, 0);
      for (int k = 1; k <= 20; k++)
         add($sformatf("drain66_%0d", k), 0, 0, 8'd0, 1,
             11'((96 - 2 * k > 66) ? 96 - 2 * k : 66), 1, k < 8, 0);
      add("hit16_tick", 0, 1, 8'd16, 1, 11'd66, 1, 1, 0);
      for (int j = 1; j <= 8; j++)
         add($sformatf("drain50_%0d", j), 0, 0, 8'd0, 1, 11'(66 - 2 * j), 1, j < 8, 0);
      add("hit10_tick", 0, 1, 8'd10, 1, 11'd50, 1, 1, 0);
      add("tick_after", 0, 0, 8'd0,  1, 11'd48, 1, 1, 0);
      for (int j = 1; j <= 4; j++)
         add($sformatf("drain40_%0d", j), 0, 0, 8'd0, 1, 11'(48 - 2 * j), 1, 1, 0);
      add("hold40",     0, 0, 8'd0,  1, 11'd40, 1, 1, 0);
      add("hit30_hp10", 0, 1, 8'd30, 0, 11'd40, 1, 1, 0);

      // Reset held, then released with no inputs.
      repeat (3) @(posedge clk);
      #1;
      check_outs("rst_held", 11'd0, 0, 0, 0);
      rst = 1'b0;
      step(0, 0, 8'd0, 0);
      check_outs("rst_release", 11'd0, 0, 0, 0);

      foreach (vecs[i]) begin
         step(vecs[i].spawn, vecs[i].dv, vecs[i].amt, vecs[i].tick);
         check_outs(vecs[i].name, vecs[i].border, vecs[i].valid, vecs[i].flash, vecs[i].dead);
      end

      // Overkill at hp 10: saturates to 0, drains 40 -> 0, then blinks and dies.
      step(0, 1, 8'd200, 0);
      check_outs("overkill", 11'd40, 1, 1, 0);
      step(0, 0, 8'd0, 0);
      check_outs("enter_dying", 11'd40, 1, 1, 0);
      for (int t = 1; t <= 68; t++) begin
         int tog;
         int b;
         step(0, 0, 8'd0, 1);
         b   = (40 - 2 * t > 0) ? 40 - 2 * t : 0;
         tog = (t >= 20) ? (t - 20) / 6 : 0;
         check_outs($sformatf("dying_%0d", t), 11'(b), (tog % 2) == 0, t < 8, 0);
         if (t == 10) begin
            step(0, 1, 8'd5, 0);
            check_outs("dying_dmg", 11'd20, 1, 0, 0);
         end
      end
      step(0, 0, 8'd0, 0);
      check_outs("dead_entry", 11'd0, 0, 0, 1);
      step(0, 1, 8'd20, 0);
      check_outs("dead_dmg", 11'd0, 0, 0, 1);
      step(0, 0, 8'd0, 1);
      check_outs("dead_tick", 11'd0, 0, 0, 1);
      step(1, 0, 8'd0, 0);
      check_outs("dead_spawn", 11'd96, 1, 0, 0);

      // Async reset mid-DYING, between clock edges.
      step(0, 1, 8'd200, 0);
      check_outs("kill", 11'd96, 1, 1, 0);
      step(0, 0, 8'd0, 0);
      for (int t = 1; t <= 3; t++) step(0, 0, 8'd0, 1);
      check_outs("dying_mid", 11'd90, 1, 1, 0);
      #2;
      rst = 1'b1;
      #1;
      check_outs("async_rst", 11'd0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      step(0, 0, 8'd0, 1);
      check_outs("post_rst_idle", 11'd0, 0, 0, 0);
      step(1, 0, 8'd0, 0);
      check_outs("post_rst_spawn", 11'd96, 1, 0, 0);
      step(0, 1, 8'd0, 0);
      check_outs("zero_dmg_hit", 11'd96, 1, 1, 0);
      step(0, 0, 8'd0, 1);
      check_outs("zero_dmg_tick", 11'd96, 1, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/enemy_health_ctrl.md
Name: enemy_health_ctrl

Overview:
Owns enemy hit points and produces the border/valid pair consumed by the enemy health bar renderer. It accepts damage events from collision logic and animates the displayed bar width toward the true HP once per video frame. On death it blinks the bar, then hides it and flags death to game-state logic. It sits between collision detection and the pixel pipeline, clocked in the pixel domain.

Parameters:
MAX_HP, 96, full HP in bar pixels; must equal the renderer's bar WIDTH.
DRAIN_STEP, 2, pixels the displayed width drops per frame tick.
HIT_FRAMES, 8, frame ticks hit_flash_out stays high after an accepted hit.
BLINK_FRAMES, 6, frame ticks per valid_out toggle while dying.
BLINK_TOGGLES, 8, number of valid_out toggles before DEAD.

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous reset, active-high
frame_tick_in  in  1  one-cycle pulse per frame (end of active video)
spawn_in  in  1  one-cycle pulse: enemy (re)spawns at full HP
damage_valid_in  in  1  one-cycle pulse: damage event
damage_amt_in  in  8  damage in HP pixels, sampled with damage_valid_in
border_out  out  11  displayed health width in pixels, 0..MAX_HP
valid_out  out  1  bar visible
hit_flash_out  out  1  high while hit flash is active
dead_out  out  1  level, high in DEAD

Behaviour:
- Reset: state IDLE; hp_target=0, border_out=0, valid_out=0, hit_flash_out=0, dead_out=0; all counters 0. rst deasserting mid-game returns to IDLE, with no partial state kept.
- All outputs are registered. Every input effect appears on outputs 1 cycle after the sampling edge.
- States: IDLE, ALIVE, DYING, DEAD.
  - IDLE: valid_out=0. spawn_in -> ALIVE.
  - ALIVE: valid_out=1.
  - DYING: draining and blinking.
  - DEAD: valid_out=0, dead_out=1.
- spawn_in has highest priority in every state:
  - Sets hp_target=border_out=MAX_HP, valid_out=1, dead_out=0, hit_flash_out=0, clears counters.
  - Next state is ALIVE.
  - A same-cycle damage pulse is ignored.
- Damage, ALIVE only:
  - hp_target <= (damage_amt_in >= hp_target) ? 0 : hp_target - damage_amt_in.
  - Saturating; no wrap. Computed at 11 bits with damage zero-extended.
  - Sets hit_flash counter to HIT_FRAMES.
  - damage_amt_in=0 is still an accepted hit (flash), with no HP change.
  - Damage in IDLE, DYING or DEAD is ignored.
- Transition ALIVE->DYING occurs on the cycle after hp_target becomes 0.
- Drain, on frame_tick_in in ALIVE or DYING:
  - If border_out > hp_target: border_out <= max(border_out - DRAIN_STEP, hp_target).
  - border_out never goes below hp_target, never exceeds MAX_HP, and never increases except via spawn.
- Simultaneous damage and frame_tick in one cycle:
  - Drain compares against the pre-damage hp_target.
  - The new target takes effect from the next tick.
- hit_flash_out: high while the flash counter is nonzero. The counter decrements on each frame_tick_in. A new hit reloads it to HIT_FRAMES.
- DYING:
  - Drain continues until border_out==0.
  - Then, on each frame_tick, the blink frame counter counts. Every BLINK_FRAMES ticks, valid_out toggles and the toggle counter increments.
  - After BLINK_TOGGLES toggles -> DEAD. valid_out=0, dead_out=1 on entry.
- DEAD: holds until spawn_in or rst.
- frame_tick_in absent: border_out, the flash counter and the blink counters freeze. Damage still updates hp_target.

Decomposition:
- Package enemy_pkg holds:
  - enum typedef health_state_t {IDLE, ALIVE, DYING, DEAD};
  - localparam BORDER_W=11;
  - the saturating-subtract function sat_sub11.
- Natural sub-module: frame_down_counter (load value, decrement on tick, zero flag). Instantiate it for the hit flash and for the blink frame counter.

Test Plan:
- rst held, then released with no inputs -> border_out=0, valid_out=0, dead_out=0, state IDLE.
- spawn_in, then damage 30, then 20 frame_ticks (defaults) -> hp_target=66. border_out steps 96,94,...,66 and stops at 66 after 15 ticks. hit_flash_out high for exactly 8 ticks.
- In ALIVE at hp 10, damage 200 -> hp_target=0, no wrap. DYING next cycle. border_out drains to 0. valid_out toggles every 6 ticks, 8 times. Then dead_out=1, valid_out=0.
- Damage and frame_tick in the same cycle at border=hp=50, damage 10 -> no drain that tick. Next tick border=48.
- Damage pulse in IDLE and in DEAD -> no change to any output. spawn_in in DEAD -> border_out=96, valid_out=1, dead_out=0 next cycle.
- Async rst asserted mid-DYING between clock edges -> outputs reach reset values immediately, without waiting for a clock edge. After release, spawn_in works normally.
